reg_display_scanner: RTL and testbench

//  Debug front-panel stage downstream of the register file's debug read port.

---
 rtl/reg_display_scanner_pkg.sv | 27 ++
 rtl/reg_display_scanner_if.sv | 31 +++
 rtl/reg_display_scanner_button_debounce.sv | 52 +++++
 rtl/reg_display_scanner.sv | 116 +++++++++++
 tb/tb_reg_display_scanner.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_display_scanner_pkg.sv
// Shared types and constants for the debug front-panel register scanner.
//   mode_t       : panel operating mode (direct / step / auto / freeze)
//   scan_state_t : two-phase refresh state (drive address, capture data)
//   SEG7_HEX     : active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   SEG7_BLANK   : all segments off
package reg_display_scanner_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_STEP   = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_t;

  typedef enum logic {
    S_ADDR    = 1'b0,
    S_CAPTURE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

endpackage

// File: rtl/reg_display_scanner_if.sv
// Bundle of panel controls, register-file debug port and display outputs.
//   mode/sw_sel/step_btn : panel controls (driven by master)
//   ra / rd              : debug read address out, combinational read data in
//   cur_reg/valid        : index currently shown, latch-holds-a-word flag
//   hex0..hex7           : active-low seven-segment digits, hex7 = MS nibble
//   state                : scanner FSM state, exported for observation
// There is no backpressure on this bundle: valid is a plain status level that
// rises on the first capture after reset and stays high; there is no ready.
interface reg_display_scanner_if;
  import reg_display_scanner_pkg::*;

  mode_t       mode;
  logic [4:0]  sw_sel;
  logic        step_btn;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic [4:0]  cur_reg;
  logic        valid;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  scan_state_t state;

  modport master (
    output mode, sw_sel, step_btn, rd,
    input  ra, cur_reg, valid, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, state
  );

  modport slave (
    input  mode, sw_sel, step_btn, rd,
    output ra, cur_reg, valid, hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, state
  );
endinterface

// File: rtl/reg_display_scanner_button_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and
// rising-edge pulse of the accepted level.
//   clk, reset : clock, asynchronous active-low reset
//   btn_i      : raw asynchronous button, active-high
//   pulse_o    : one-cycle pulse when the accepted level goes 0 -> 1
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          pulse_q;

  // The counter only runs while the synced input disagrees with the accepted
  // level; any agreement restarts it, so short glitches never flip the level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_MAX) begin
          level_q <= ~level_q;
          cnt_q   <= '0;
          pulse_q <= ~level_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/reg_display_scanner.sv
// Debug front-panel scanner: picks a register index (switches, debounced step
// button or auto-scroll), reads it over the debug port, latches the word and
// drives eight registered active-low seven-segment digits.
//   clk, reset : CPU clock, asynchronous active-low reset
//   bus        : panel controls, debug read port and display (slave side)
module reg_display_scanner
  import reg_display_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned SCROLL_CYCLES   = 50_000_000,
  parameter int unsigned FIRST_REG       = 2,
  parameter int unsigned LAST_REG        = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_display_scanner_if.slave bus
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);
  localparam int unsigned SW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [SW-1:0] SCROLL_MAX = SW'(SCROLL_CYCLES - 1);

  logic          step_pulse;
  logic [SW-1:0] scroll_q;
  logic          tick;
  logic          advance;
  logic [4:0]    idx_q, idx_d;

  scan_state_t   state_q;
  logic [4:0]    ra_q, cur_reg_q;
  logic [31:0]   latch_q;
  logic          valid_q;
  logic [6:0]    hex_q [8];

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (bus.step_btn),
    .pulse_o(step_pulse)
  );

  // Scroll timer is held at zero outside auto mode, so re-entering auto
  // always waits one full period before the first step.
  assign tick = (bus.mode == MODE_AUTO) && (scroll_q == SCROLL_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     scroll_q <= '0;
    else if (bus.mode != MODE_AUTO) scroll_q <= '0;
    else if (tick)                  scroll_q <= '0;
    else                            scroll_q <= scroll_q + 1'b1;
  end

  // Step pulses count only in step mode; tick only exists in auto mode,
  // so a coincident pulse and tick can never advance twice.
  assign advance = ((bus.mode == MODE_STEP) && step_pulse) || tick;

  always_comb begin
    idx_d = idx_q;
    if (advance) idx_d = (idx_q == LAST_IDX) ? FIRST_IDX : idx_q + 5'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idx_q <= FIRST_IDX;
    else        idx_q <= idx_d;
  end

  // Refresh FSM: drive the address one cycle, capture the read data the next.
  // Freeze parks it in S_ADDR so the latch and cur_reg stop updating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_ADDR;
      ra_q      <= FIRST_IDX;
      latch_q   <= '0;
      cur_reg_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (bus.mode != MODE_FREEZE) begin
            ra_q    <= (bus.mode == MODE_DIRECT) ? bus.sw_sel : idx_q;
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          latch_q   <= bus.rd;
          cur_reg_q <= ra_q;
          valid_q   <= 1'b1;
          state_q   <= S_ADDR;
        end
        default: state_q <= S_ADDR;
      endcase
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_hex
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) hex_q[g] <= SEG7_HEX[0];
      else        hex_q[g] <= SEG7_HEX[latch_q[4*g +: 4]];
    end
  end

  assign bus.ra      = ra_q;
  assign bus.cur_reg = cur_reg_q;
  assign bus.valid   = valid_q;
  assign bus.state   = state_q;
  assign bus.hex0    = hex_q[0];
  assign bus.hex1    = hex_q[1];
  assign bus.hex2    = hex_q[2];
  assign bus.hex3    = hex_q[3];
  assign bus.hex4    = hex_q[4];
  assign bus.hex5    = hex_q[5];
  assign bus.hex6    = hex_q[6];
  assign bus.hex7    = hex_q[7];

endmodule

// File: tb/tb_reg_display_scanner.sv
// Bench for reg_display_scanner with short debounce/scroll periods and a
// simple register-file model (reg[i] = 0x1000_0000 + i, reg0 reads 0).
module tb_reg_display_scanner;
  import reg_display_scanner_pkg::*;

  localparam int DEB    = 4;
  localparam int SCROLL = 8;
  localparam int FIRSTR = 2;
  localparam int LASTR  = 25;

  logic clk;
  logic reset;
  reg_display_scanner_if bus ();

  reg_display_scanner #(
    .DEBOUNCE_CYCLES(DEB),
    .SCROLL_CYCLES  (SCROLL),
    .FIRST_REG      (FIRSTR),
    .LAST_REG       (LASTR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file model ----------------
  logic [31:0] rf [32];
  assign bus.rd = (bus.ra == 5'd0) ? 32'h0 : rf[bus.ra];

  // ---------------- reference model ----------------
  int    errors = 0;
  int    checks = 0;
  int    model_idx;
  mode_t cur_mode;

  function automatic int next_idx(input int i);
    return (i == LASTR) ? FIRSTR : i + 1;
  endfunction

  function automatic logic [31:0] reg_word(input int i);
    return (i == 0) ? 32'h0 : rf[i];
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] hex_out(input int n);
    case (n)
      0: return bus.hex0; 1: return bus.hex1; 2: return bus.hex2; 3: return bus.hex3;
      4: return bus.hex4; 5: return bus.hex5; 6: return bus.hex6; default: return bus.hex7;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_display(input string tag, input logic [31:0] word);
    for (int n = 0; n < 8; n++) begin
      logic [3:0] nib;
      nib = word[4*n +: 4];
      check($sformatf("%s_hex%0d", tag, n), {25'b0, hex_out(n)}, {25'b0, seg_of(nib)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input mode_t m);
    cur_mode = m;
    bus.mode = m;
  endtask

  // Holds the button for len sampling edges then releases and lets it settle.
  task automatic press(input int len);
    bus.step_btn = 1'b1;
    repeat (len) @(posedge clk);
    #1 bus.step_btn = 1'b0;
    cycles(14);
    if (cur_mode == MODE_STEP && len >= DEB) model_idx = next_idx(model_idx);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          prev, nchg, last_t, first_t, len;
    logic [4:0]  sel;
    logic [31:0] old_word;

    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[0] = 32'h0;
    bus.sw_sel   = 5'd0;
    bus.step_btn = 1'b0;
    set_mode(MODE_STEP);
    model_idx = FIRSTR;

    // Reset state
    reset = 1'b0;
    #12;
    check("rst_valid", {31'b0, bus.valid}, 32'd0);
    check("rst_cur_reg", {27'b0, bus.cur_reg}, 32'd0);
    check("rst_ra", {27'b0, bus.ra}, FIRSTR);
    check_display("rst", 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    cycles(5);
    check("boot_valid", {31'b0, bus.valid}, 32'd1);
    check("boot_cur_reg", {27'b0, bus.cur_reg}, model_idx);
    check_display("boot", reg_word(model_idx));

    // Direct mode
    set_mode(MODE_DIRECT);
    bus.sw_sel = 5'd5;
    cycles(2);
    check("direct_ra", {27'b0, bus.ra}, 32'd5);
    cycles(2);
    check("direct_cur_reg", {27'b0, bus.cur_reg}, 32'd5);
    check_display("direct5", reg_word(5));
    for (int k = 0; k < 6; k++) begin
      sel = (k == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      bus.sw_sel = sel;
      cycles(4);
      check("direct_rand_cur_reg", {27'b0, bus.cur_reg}, {27'b0, sel});
      check_display("direct_rand", reg_word(int'(sel)));
    end

    // Debounce: short glitch, clean press, press with bounces
    set_mode(MODE_STEP);
    cycles(4);
    press(2);
    check("glitch_no_step", {27'b0, bus.cur_reg}, model_idx);
    press(10);
    check("press_cur_reg", {27'b0, bus.cur_reg}, 32'd3);
    check("press_hex0", {25'b0, bus.hex0}, 32'h30);
    bus.step_btn = 1'b1; cycles(6);
    bus.step_btn = 1'b0; cycles(2);
    bus.step_btn = 1'b1; cycles(6);
    bus.step_btn = 1'b0; cycles(14);
    model_idx = next_idx(model_idx);
    check("bounce_one_step", {27'b0, bus.cur_reg}, model_idx);
    check_display("bounce", reg_word(model_idx));

    // Random presses and glitches up to the top of the range
    while (model_idx != LASTR) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEB - 1)
                                        : $urandom_range(DEB + 1, 12);
      press(len);
      check("rand_press_cur_reg", {27'b0, bus.cur_reg}, model_idx);
    end
    check_display("at_last", reg_word(LASTR));

    // Wrap LAST_REG -> FIRST_REG
    press(8);
    check("wrap_cur_reg", {27'b0, bus.cur_reg}, FIRSTR);
    check("wrap_hex0", {25'b0, bus.hex0}, 32'h24);

    // Auto scroll, with an ignored button press in the middle
    set_mode(MODE_AUTO);
    prev = int'(bus.cur_reg);
    nchg = 0; last_t = 0; first_t = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 20) bus.step_btn = 1'b1;
      if (c == 32) bus.step_btn = 1'b0;
      @(posedge clk); #1;
      if (int'(bus.cur_reg) != prev) begin
        model_idx = next_idx(model_idx);
        check("auto_step", {27'b0, bus.cur_reg}, model_idx);
        if (nchg > 0) check("auto_period", c - last_t, SCROLL);
        else first_t = c;
        nchg++;
        last_t = c;
        prev = int'(bus.cur_reg);
      end
    end
    check("auto_count", nchg, 7);
    check("auto_first_in_window", {31'b0, (first_t >= SCROLL + 2) && (first_t <= SCROLL + 3)}, 32'd1);
    set_mode(MODE_STEP);
    cycles(5);
    check("auto_exit_cur_reg", {27'b0, bus.cur_reg}, model_idx);
    check_display("auto_exit", reg_word(model_idx));

    // Freeze: register write is not shown until the mode changes
    set_mode(MODE_FREEZE);
    cycles(4);
    old_word = reg_word(model_idx);
    rf[model_idx] = 32'hDEADBEEF;
    cycles(10);
    check_display("freeze_held", old_word);
    check("freeze_cur_reg", {27'b0, bus.cur_reg}, model_idx);
    set_mode(MODE_STEP);
    cycles(3);
    check_display("unfreeze", 32'hDEADBEEF);

    // Reset in the middle of a press discards the partial debounce count
    bus.step_btn = 1'b1;
    cycles(2);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", {31'b0, bus.valid}, 32'd0);
    check("midrst_cur_reg", {27'b0, bus.cur_reg}, 32'd0);
    check("midrst_ra", {27'b0, bus.ra}, FIRSTR);
    check_display("midrst", 32'h0);
    #2 reset = 1'b1;
    model_idx = FIRSTR;
    @(posedge clk); @(posedge clk); #1 bus.step_btn = 1'b0;
    cycles(14);
    check("midrst_no_step", {27'b0, bus.cur_reg}, model_idx);
    check("midrst_valid_back", {31'b0, bus.valid}, 32'd1);
    check_display("midrst_after", reg_word(model_idx));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
